// File: rtl/exibe_sequencia.sv
// ============================================================================
// Module   : exibe_sequencia
// Function : Presents the stored play sequence on the LEDs, one play at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exibe_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500,
    parameter int TW    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        CARREGA = 4'h1,
        MOSTRA  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t       estado;
    estado_t       estado_prox;
    logic [TW-1:0] timer;
    logic [3:0]    limite_reg;
    logic          fim_on;
    logic          fim_off;
    logic          ultimo;

    assign fim_on  = (timer == ON_LAST);
    assign fim_off = (timer == OFF_LAST);
    assign ultimo  = (endereco == limite_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL: if (iniciar) estado_prox = CARREGA;
            CARREGA: estado_prox = MOSTRA;
            MOSTRA:  if (fim_on) estado_prox = APAGA;
            APAGA:   if (fim_off) estado_prox = ultimo ? FIM : PROXIMO;
            PROXIMO: estado_prox = CARREGA;
            FIM:     estado_prox = INICIAL;
            default: estado_prox = INICIAL;
        endcase
    end

    // The address advances on the apaga exit edge so that, with the memory's
    // registered read, dado already holds the new play by the end of carrega.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco   <= 4'h0;
            leds       <= 4'h0;
            timer      <= '0;
            limite_reg <= 4'h0;
        end else begin
            case (estado)
                INICIAL: begin
                    endereco <= 4'h0;
                    leds     <= 4'h0;
                    timer    <= '0;
                    if (iniciar) limite_reg <= limite;
                end
                CARREGA: begin
                    leds  <= dado;
                    timer <= '0;
                end
                MOSTRA: begin
                    if (fim_on) begin
                        timer <= '0;
                        leds  <= 4'h0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGA: begin
                    if (fim_off) begin
                        timer    <= '0;
                        endereco <= ultimo ? 4'h0 : endereco + 4'h1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PROXIMO: begin
                    timer <= '0;
                end
                FIM: begin
                    endereco <= 4'h0;
                    leds     <= 4'h0;
                    timer    <= '0;
                end
                default: begin
                    endereco <= 4'h0;
                    leds     <= 4'h0;
                    timer    <= '0;
                end
            endcase
        end
    end

    assign exibindo  = (estado == CARREGA) || (estado == MOSTRA) ||
                       (estado == APAGA)   || (estado == PROXIMO);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

endmodule

`default_nettype wire
